// File: rtl/cubehash_iter_core.sv
// cubehash_iter_core: iterative CubeHash absorb/pad/finalise core; CUBEHASH_IV_GEN_EN adds an on-chip IV generator
module cubehash_iter_core #(
    parameter int BLOCK_BYTES  = 32,
    parameter int ROUNDS       = 16,
    parameter int FINAL_ROUNDS = 160,
    parameter int UNROLL       = 1,
    parameter int HASH_BITS    = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*BLOCK_BYTES-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HASH_BITS-1:0]     hash,
    output logic                     busy
);
    typedef logic [31:0][31:0] st_t;
    typedef enum logic [2:0] {IDLE, ABSORB, PAD, FLIP, FINAL, OUT, IVGEN} state_t;

    localparam int RB = ROUNDS / UNROLL;
    localparam int FB = FINAL_ROUNDS / UNROLL;
`ifdef CUBEHASH_IV_GEN_EN
    localparam int GB = 10 * RB;
    localparam int CMAX = GB > FB ? GB : FB;
    localparam state_t RST_ST = IVGEN;
`else
    localparam int CMAX = FB;
    localparam state_t RST_ST = IDLE;
`endif
    localparam int RCW = $clog2(CMAX) + 1;

    // Reset contents of the state words: generator seed, or the CubeHash16/32-512 IV (x31 first)
    function automatic st_t seed_f();
        st_t s;
        s = '0;
`ifdef CUBEHASH_IV_GEN_EN
        s[0] = 32'(HASH_BITS / 8);
        s[1] = 32'(BLOCK_BYTES);
        s[2] = 32'(ROUNDS);
`else
        s = {32'hd43e3b44, 32'h7795d246, 32'he7989af1, 32'h1921c8f7,
             32'hbc796576, 32'hb1c62456, 32'ha5a70e75, 32'hd65c8a2b,
             32'h0dbadea9, 32'h91fa7934, 32'h2ff5781c, 32'h6a536159,
             32'hb6444532, 32'h1b017bef, 32'h148fe485, 32'hfcd398d9,
             32'ha23911ae, 32'hd0e5cd33, 32'hf22090c4, 32'heef864d2,
             32'h825b4537, 32'h97cf0bef, 32'ha647a8b3, 32'h4d42c787,
             32'h50ac5695, 32'hcc39968e, 32'hc701cf8c, 32'h3fee2313,
             32'h4167d83e, 32'h2d538b8b, 32'h50f494d4, 32'h2aea2a61};
`endif
        return s;
    endfunction

    localparam st_t X0 = seed_f();

    // Half-mix: add, rotate by r, swap low words by p, xor, swap high words by q
    function automatic st_t half_f(input st_t a, input int r, input int p, input int q);
        st_t s;
        st_t t;
        s = a;
        for (int i = 0; i < 16; i++) s[i+16] = s[i+16] + s[i];
        for (int i = 0; i < 16; i++) s[i] = (s[i] << r) | (s[i] >> (32 - r));
        t = s;
        for (int i = 0; i < 16; i++) s[i] = t[i^p] ^ t[i+16];
        t = s;
        for (int i = 0; i < 16; i++) s[i+16] = t[(i^q)+16];
        return s;
    endfunction

    function automatic st_t round_f(input st_t a);
        return half_f(half_f(a, 7, 8, 2), 11, 4, 1);
    endfunction

    // Digest byte k is byte k%4 (little-endian) of word k/4, first byte in the MSBs
    function automatic logic [HASH_BITS-1:0] pack_f(input st_t s);
        logic [HASH_BITS-1:0] h;
        h = '0;
        for (int k = 0; k < HASH_BITS / 8; k++) h[HASH_BITS-8-8*k +: 8] = s[k/4][8*(k%4) +: 8];
        return h;
    endfunction

    state_t state, state_n;
    logic [RCW-1:0] rc, rc_n;
    st_t x, x_n, rnd, iv;
    logic last_f, last_n, live;
    logic [HASH_BITS-1:0] hash_n;

`ifdef CUBEHASH_IV_GEN_EN
    st_t iv_q, iv_n;
    assign iv = iv_q;

    // Generated IV, captured when the IVGEN run completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) iv_q <= '0;
        else iv_q <= iv_n;
    end
`else
    assign iv = X0;

    if (HASH_BITS != 512 || BLOCK_BYTES != 32 || ROUNDS != 16) begin : g_iv_check
        $error("cubehash_iter_core: hard-wired IV requires HASH_BITS=512, BLOCK_BYTES=32, ROUNDS=16");
    end
`endif

    // live holds in_ready low for the first edge after reset release
    assign in_ready  = live && state == IDLE;
    assign busy      = !in_ready;
    assign out_valid = state == OUT;

    // UNROLL rounds chained combinationally
    always_comb begin
        rnd = x;
        for (int u = 0; u < UNROLL; u++) rnd = round_f(rnd);
    end

    // State, counter and register updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RST_ST;
            rc     <= '0;
            x      <= X0;
            last_f <= 1'b0;
            hash   <= '0;
            live   <= 1'b0;
        end else begin
            state  <= state_n;
            rc     <= rc_n;
            x      <= x_n;
            last_f <= last_n;
            hash   <= hash_n;
            live   <= 1'b1;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n = state;
        rc_n    = rc;
        x_n     = x;
        last_n  = last_f;
        hash_n  = hash;
`ifdef CUBEHASH_IV_GEN_EN
        iv_n    = iv_q;
`endif
        case (state)
            IDLE: if (in_valid && in_ready) begin
                for (int k = 0; k < BLOCK_BYTES; k++)
                    x_n[k/4][8*(k%4) +: 8] = x[k/4][8*(k%4) +: 8] ^ in_data[8*(BLOCK_BYTES-1-k) +: 8];
                last_n  = in_last;
                rc_n    = '0;
                state_n = ABSORB;
            end
            ABSORB: begin
                x_n  = rnd;
                rc_n = rc + RCW'(1);
                if (rc == RCW'(RB - 1)) begin
                    rc_n    = '0;
                    state_n = last_f ? PAD : IDLE;
                end
            end
            PAD: begin
                if (rc == '0) x_n[0] = x[0] ^ 32'h0000_0080;
                else x_n = rnd;
                rc_n = rc + RCW'(1);
                if (rc == RCW'(RB)) begin
                    rc_n    = '0;
                    state_n = FLIP;
                end
            end
            FLIP: begin
                x_n[31] = x[31] ^ 32'd1;
                state_n = FINAL;
            end
            FINAL: begin
                x_n  = rnd;
                rc_n = rc + RCW'(1);
                if (rc == RCW'(FB - 1)) begin
                    rc_n    = '0;
                    hash_n  = pack_f(rnd);
                    state_n = OUT;
                end
            end
            OUT: if (out_ready) begin
                x_n     = iv;
                state_n = IDLE;
            end
`ifdef CUBEHASH_IV_GEN_EN
            IVGEN: begin
                x_n  = rnd;
                rc_n = rc + RCW'(1);
                if (rc == RCW'(GB - 1)) begin
                    rc_n    = '0;
                    iv_n    = rnd;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule
